// File: rtl/scan_pkg.sv
// ---------------------------------------------------------------------------
// scan_pkg
// Shared definitions for the display scanner and anything that drives or
// observes it: digit geometry, bank types and the anode-select bit reversal.
// No ports (package).
// ---------------------------------------------------------------------------
package scan_pkg;

  localparam int NUM_DIGITS = 8;
  localparam int IDX_W      = 3;

  typedef logic [3:0]                digit_t;
  typedef digit_t [NUM_DIGITS-1:0]   digit_bank_t;

  // The downstream decoder reads its anode index as {sel[0],sel[1],sel[2]},
  // so the scanner presents the index bit-reversed to light anode N for idx N.
  function automatic logic [IDX_W-1:0] sel_of(input logic [IDX_W-1:0] idx);
    return {idx[0], idx[1], idx[2]};
  endfunction

endpackage

// File: rtl/refresh_prescaler.sv
// ---------------------------------------------------------------------------
// refresh_prescaler
// Free-running divider producing one tick every REFRESH_DIV clock cycles.
// Ports:
//   clk  - system clock, rising edge
//   rst  - asynchronous active-high reset (counter returns to 0)
//   tick - high during the last cycle of each REFRESH_DIV-cycle slot
// ---------------------------------------------------------------------------
module refresh_prescaler #(
  parameter int REFRESH_DIV = 100000
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int               CNT_W = $clog2(REFRESH_DIV + 1);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(REFRESH_DIV - 1);

  logic [CNT_W-1:0] r_cnt;

  // With REFRESH_DIV=1 the counter is pinned at 0 and tick is constant high.
  assign tick = (r_cnt == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/display_scanner.sv
// ---------------------------------------------------------------------------
// display_scanner
// Double-buffered 8-digit bank time-multiplexed onto a seven-segment decoder.
// Writes land in a shadow bank; a commit publishes the shadow bank into the
// displayed bank only on a frame wrap, so a frame is never torn.
//
// Ports:
//   clk, rst        - clock / asynchronous active-high reset
//   wr_en/addr/data/dp - shadow bank write port
//   commit          - single-cycle publish request
//   digit_en        - per-digit scan enable (SCAN_SKIP_EN builds only)
//   num, sel, dp_out - registered decoder drive (sel is bit-reversed idx)
//   commit_pending  - publish requested but not yet performed
//   frame_start     - one-cycle pulse after the scan wraps to its first digit
//
// Build option: define SCAN_SKIP_EN to skip digits whose digit_en bit is 0.
// ---------------------------------------------------------------------------
module display_scanner
  import scan_pkg::*;
#(
  parameter int REFRESH_DIV = 100000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_addr,
  input  logic [3:0]       wr_data,
  input  logic             wr_dp,
  input  logic             commit,
  input  logic [NUM_DIGITS-1:0] digit_en,
  output logic [3:0]       num,
  output logic [IDX_W-1:0] sel,
  output logic             dp_out,
  output logic             commit_pending,
  output logic             frame_start
);

  logic                  w_tick;
  logic [IDX_W-1:0]      w_next;
  logic                  w_wrap;
  logic                  w_blank;
  logic                  w_copy;

  logic [IDX_W-1:0]      r_idx;
  digit_bank_t           r_shadow;
  digit_bank_t           r_active;
  logic [NUM_DIGITS-1:0] r_shadow_dp;
  logic [NUM_DIGITS-1:0] r_active_dp;
  digit_t                r_num;
  logic [IDX_W-1:0]      r_sel;
  logic                  r_dp;
  logic                  r_pending;
  logic                  r_frame_start;

  refresh_prescaler #(
    .REFRESH_DIV (REFRESH_DIV)
  ) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .tick (w_tick)
  );

`ifdef SCAN_SKIP_EN
  logic             w_found;
  logic [IDX_W-1:0] w_cand;

  // Cyclic search for the first enabled digit strictly after r_idx. Offset 8
  // truncates back to r_idx itself, so a lone enabled digit rescans itself
  // and that counts as a wrap.
  always_comb begin
    w_next  = '0;
    w_found = 1'b0;
    w_cand  = '0;
    for (int k = 1; k <= NUM_DIGITS; k++) begin
      w_cand = r_idx + IDX_W'(k);
      if (!w_found && digit_en[w_cand]) begin
        w_next  = w_cand;
        w_found = 1'b1;
      end
    end
    // No enabled digits: park on 0 with a blank output; every tick is a wrap
    // so pending commits are still published.
    w_blank = !w_found;
    w_wrap  = !w_found || (w_next <= r_idx);
  end
`else
  logic w_unused_digit_en;
  assign w_unused_digit_en = ^digit_en;

  always_comb begin
    w_next  = r_idx + 1'b1;
    w_wrap  = (r_idx == IDX_W'(NUM_DIGITS - 1));
    w_blank = 1'b0;
  end
`endif

  assign w_copy = w_tick & w_wrap & r_pending;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idx         <= '0;
      r_shadow      <= '0;
      r_active      <= '0;
      r_shadow_dp   <= '0;
      r_active_dp   <= '0;
      r_num         <= '0;
      r_sel         <= '0;
      r_dp          <= 1'b0;
      r_pending     <= 1'b0;
      r_frame_start <= 1'b0;
    end else begin
      // The copy below reads the pre-edge shadow, so a write on the copy
      // edge stays in the shadow for the following frame.
      if (wr_en) begin
        r_shadow[wr_addr]    <= wr_data;
        r_shadow_dp[wr_addr] <= wr_dp;
      end

      // A commit on the copy edge wins, re-arming publication next frame.
      if (commit) begin
        r_pending <= 1'b1;
      end else if (w_copy) begin
        r_pending <= 1'b0;
      end

      r_frame_start <= w_tick & w_wrap;

      if (w_tick) begin
        r_idx <= w_next;
        r_sel <= sel_of(w_next);
        if (w_copy) begin
          r_active    <= r_shadow;
          r_active_dp <= r_shadow_dp;
        end
        if (w_blank) begin
          r_num <= '0;
          r_dp  <= 1'b0;
        end else if (w_copy) begin
          // Bypass: the first digit of the new frame already shows new data.
          r_num <= r_shadow[w_next];
          r_dp  <= r_shadow_dp[w_next];
        end else begin
          r_num <= r_active[w_next];
          r_dp  <= r_active_dp[w_next];
        end
      end
    end
  end

  assign num            = r_num;
  assign sel            = r_sel;
  assign dp_out         = r_dp;
  assign commit_pending = r_pending;
  assign frame_start    = r_frame_start;

endmodule

// File: tb/tb_display_scanner.sv
module tb_display_scanner;
  import scan_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, rst1;
  logic       wr_en, wr_dp, commit;
  logic [2:0] wr_addr;
  logic [3:0] wr_data;
  logic [7:0] digit_en;

  logic [3:0] num,  num1;
  logic [2:0] sel,  sel1;
  logic       dp_out, dp_out1;
  logic       commit_pending, commit_pending1;
  logic       frame_start, frame_start1;

  display_scanner #(.REFRESH_DIV(4)) u_dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_dp(wr_dp), .commit(commit), .digit_en(digit_en), .num(num), .sel(sel),
    .dp_out(dp_out), .commit_pending(commit_pending), .frame_start(frame_start)
  );

  display_scanner #(.REFRESH_DIV(1)) u_dut1 (
    .clk(clk), .rst(rst1), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_dp(wr_dp), .commit(commit), .digit_en(digit_en), .num(num1), .sel(sel1),
    .dp_out(dp_out1), .commit_pending(commit_pending1), .frame_start(frame_start1)
  );

  int n_pass  = 0;
  int n_total = 0;
  int e;                       // clock edges since reset release (DIV=4 dut)

  // Reference state for the DIV=4 instance.
  logic [3:0] m_act [8];
  logic [3:0] m_sh  [8];
  logic       m_adp [8];
  logic       m_sdp [8];
  logic       m_pend;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s e=%0d observed=%0h expected=%0h", tag, e, obs, exp);
  endtask

  task automatic model_clear();
    for (int i = 0; i < 8; i++) begin
      m_act[i] = 4'h0; m_sh[i] = 4'h0; m_adp[i] = 1'b0; m_sdp[i] = 1'b0;
    end
    m_pend = 1'b0;
  endtask

  // One clock of the DIV=4 dut; model updates from inputs held across the edge.
  task automatic cyc();
    bit tk, wr, cp;
    tk = ((e % 4) == 3);
    wr = tk && (((e / 4) % 8) == 7);
    cp = wr && m_pend;
    @(posedge clk);
    if (cp) begin
      m_act = m_sh;
      m_adp = m_sdp;
    end
    if (wr_en) begin
      m_sh[wr_addr]  = wr_data;
      m_sdp[wr_addr] = wr_dp;
    end
    if (commit) m_pend = 1'b1;
    else if (cp) m_pend = 1'b0;
    e++;
    @(negedge clk);
  endtask

  task automatic check_scan();
    int idx;
    idx = (e / 4) % 8;
    check("sel",    {5'd0, sel},       {5'd0, sel_of(3'(idx))});
    check("num",    {4'd0, num},       {4'd0, m_act[idx]});
    check("dp",     {7'd0, dp_out},    {7'd0, m_adp[idx]});
    check("pend",   {7'd0, commit_pending}, {7'd0, m_pend});
    check("fstart", {7'd0, frame_start},    {7'd0, 1'((e > 0) && (e % 32 == 0))});
  endtask

  task automatic run(input int n);
    repeat (n) begin
      cyc();
      check_scan();
    end
  endtask

  initial begin
    rst = 1'b1; rst1 = 1'b1;
    wr_en = 1'b0; wr_addr = 3'd0; wr_data = 4'h0; wr_dp = 1'b0;
    commit = 1'b0; digit_en = 8'hFF;
    e = 0;
    model_clear();

    // Reset state
    @(negedge clk);
    check("rst_num",  {4'd0, num}, 8'h00);
    check("rst_sel",  {5'd0, sel}, 8'h00);
    check("rst_dp",   {7'd0, dp_out}, 8'h00);
    check("rst_pend", {7'd0, commit_pending}, 8'h00);
    check("rst_fs",   {7'd0, frame_start}, 8'h00);
    @(negedge clk);
    rst = 1'b0;

    // Free scan with empty bank: sel walks 000,100,010,...; wrap at edge 32
    run(40);

    // Load shadow 1..8, dp on digit 3
    for (int i = 0; i < 8; i++) begin
      wr_en = 1'b1; wr_addr = 3'(i); wr_data = 4'(i + 1); wr_dp = (i == 3);
      run(1);
    end
    wr_en = 1'b0; wr_dp = 1'b0;

    // Mid-frame commit (e=48, idx 4)
    commit = 1'b1;
    run(1);
    commit = 1'b0;
    check("pend_rise", {7'd0, commit_pending}, 8'h01);
    run(15);                                    // e=64: publish edge
    check("pub_num",  {4'd0, num}, 8'h01);
    check("pub_sel",  {5'd0, sel}, 8'h00);
    check("pub_pend", {7'd0, commit_pending}, 8'h00);
    check("pub_fs",   {7'd0, frame_start}, 8'h01);
    run(12);                                    // e=76: idx 3
    check("idx3_num", {4'd0, num}, 8'h04);
    check("idx3_dp",  {7'd0, dp_out}, 8'h01);
    check("idx3_sel", {5'd0, sel}, 8'h06);
    run(24);                                    // e=100

    // Shadow0 = A, commit, then write F + commit on the copy edge
    wr_en = 1'b1; wr_addr = 3'd0; wr_data = 4'hA;
    run(1);
    wr_en = 1'b0;
    commit = 1'b1;
    run(1);
    commit = 1'b0;
    run(25);                                    // e=127: copy edge next
    wr_en = 1'b1; wr_addr = 3'd0; wr_data = 4'hF; commit = 1'b1;
    run(1);
    wr_en = 1'b0; commit = 1'b0;
    check("cpedge_num",  {4'd0, num}, 8'h0A);
    check("cpedge_pend", {7'd0, commit_pending}, 8'h01);
    run(32);                                    // e=160: next publish
    check("repub_num",  {4'd0, num}, 8'h0F);
    check("repub_pend", {7'd0, commit_pending}, 8'h00);

    // Reset mid-operation with pending=1 at idx 5
    commit = 1'b1;
    run(1);
    commit = 1'b0;
    run(19);                                    // e=180: idx 5
    check("pre_rst_sel",  {5'd0, sel}, 8'h05);
    check("pre_rst_pend", {7'd0, commit_pending}, 8'h01);
    rst = 1'b1;
    #1;
    check("arst_num",  {4'd0, num}, 8'h00);
    check("arst_sel",  {5'd0, sel}, 8'h00);
    check("arst_dp",   {7'd0, dp_out}, 8'h00);
    check("arst_pend", {7'd0, commit_pending}, 8'h00);
    check("arst_fs",   {7'd0, frame_start}, 8'h00);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    e = 0;
    model_clear();
    run(32);                                    // discarded commit never publishes
    check("post_rst_num", {4'd0, num}, 8'h00);
    check("post_rst_fs",  {7'd0, frame_start}, 8'h01);

    // REFRESH_DIV=1 instance: idx every cycle, frame_start every 8
    rst1 = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      @(posedge clk);
      @(negedge clk);
      check("div1_sel", {5'd0, sel1}, {5'd0, sel_of(3'(k % 8))});
      check("div1_fs",  {7'd0, frame_start1}, {7'd0, 1'((k % 8) == 0)});
    end

`ifdef SCAN_SKIP_EN
    rst = 1'b1;
    @(negedge clk);
    digit_en = 8'b1000_0101;
    rst = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("skip_idx2", {5'd0, sel}, 8'h02);
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("skip_idx7", {5'd0, sel}, 8'h07);
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("skip_idx0", {5'd0, sel}, 8'h00);
    check("skip_fs",   {7'd0, frame_start}, 8'h01);
    wr_en = 1'b1; wr_addr = 3'd0; wr_data = 4'h5;
    @(posedge clk); @(negedge clk);
    wr_en = 1'b0; commit = 1'b1;
    @(posedge clk); @(negedge clk);
    commit = 1'b0; digit_en = 8'h00;
    check("skip_pend", {7'd0, commit_pending}, 8'h01);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("none_sel",  {5'd0, sel}, 8'h00);
    check("none_num",  {4'd0, num}, 8'h00);
    check("none_pend", {7'd0, commit_pending}, 8'h00);
    digit_en = 8'h01;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("solo_num", {4'd0, num}, 8'h05);
    check("solo_sel", {5'd0, sel}, 8'h00);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
